// File: rtl/mac_pkg.sv
// mac_pkg: shared lane count, FSM state types and counter type for the
// receive-side lane de-blocker (mac_deblock / mac_lane_buf).
package mac_pkg;

  localparam int MAC_LANES = 8;

  typedef enum logic {L_FILL, L_DONE} lane_state_t;

  typedef enum logic {G_COLLECT, G_OUT} glob_state_t;

  typedef logic [11:0] mac_cnt_t;

endpackage

// File: rtl/mac_lane_buf.sv
// mac_lane_buf: one byte lane of the de-blocker. Buffers a single frame of up
// to RS_CNT bytes, records its length and exposes a zero-padded read port.
// Optional length checking is built when MAC_LEN_CHK_EN is defined.
module mac_lane_buf
  import mac_pkg::*;
#(
  parameter int RS_CNT = 236
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic        clear,
  input  logic [11:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        len_err
);

  localparam int       AW       = (RS_CNT > 1) ? $clog2(RS_CNT) : 1;
  localparam mac_cnt_t LAST_IDX = mac_cnt_t'(RS_CNT - 1);

  lane_state_t state;
  mac_cnt_t    wr_cnt;
  mac_cnt_t    len;
  logic [7:0]  mem [0:(1<<AW)-1];
  logic        hs;
  logic        complete;

  assign ready    = (state == L_FILL) && !reset;
  assign hs       = valid && ready;
  assign complete = hs && (last || (wr_cnt == LAST_IDX));
  assign done     = (state == L_DONE);

  // Lane FSM: fill until tlast or the final byte slot, then hold until cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= L_FILL;
      wr_cnt <= '0;
      len    <= '0;
    end else if (clear) begin
      state  <= L_FILL;
      wr_cnt <= '0;
    end else if (hs) begin
      wr_cnt <= wr_cnt + 12'd1;
      if (complete) begin
        len   <= wr_cnt + 12'd1;
        state <= L_DONE;
      end
    end
  end

  // Byte storage, written on every accepted input byte
  always_ff @(posedge clk) begin
    if (hs) begin
      mem[wr_cnt[AW-1:0]] <= data;
    end
  end

  // Bytes beyond the received length read back as zero padding
  assign rd_data = (rd_addr < len) ? mem[rd_addr[AW-1:0]] : 8'h00;

`ifdef MAC_LEN_CHK_EN
  // One-cycle pulse after completion on a short frame or a missing tlast
  always_ff @(posedge clk) begin
    if (reset) begin
      len_err <= 1'b0;
    end else begin
      len_err <= complete && (!last || (wr_cnt != LAST_IDX));
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: rtl/mac_deblock.sv
// mac_deblock: collects one frame from each of 8 byte lanes and re-interleaves
// them into RS_CNT 64-bit words (lane j at [8j+7:8j]).
// Optional macro: MAC_LEN_CHK_EN enables per-lane frame-length error pulses.
module mac_deblock
  import mac_pkg::*;
#(
  parameter int RS_CNT = 236
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_axis_input_tvalid,
  output logic [7:0]  s_axis_input_tready,
  input  logic [63:0] s_axis_input_tdata,
  input  logic [7:0]  s_axis_input_tlast,
  output logic        m_axis_output_tvalid,
  input  logic        m_axis_output_tready,
  output logic [63:0] m_axis_output_tdata,
  output logic        m_axis_output_tlast,
  output logic [7:0]  len_err
);

  localparam mac_cnt_t LAST_IDX = mac_cnt_t'(RS_CNT - 1);

  glob_state_t          gstate;
  mac_cnt_t             rd_cnt;
  logic [MAC_LANES-1:0] lane_done;
  logic [63:0]          word;
  logic                 clear;
  logic                 load;

  // Final-word handshake releases every lane for the next frame
  assign clear = (gstate == G_OUT) && m_axis_output_tvalid &&
                 m_axis_output_tready && m_axis_output_tlast;
  assign load  = (gstate == G_OUT) && (!m_axis_output_tvalid || m_axis_output_tready);

  for (genvar j = 0; j < MAC_LANES; j++) begin : g_lane
    mac_lane_buf #(
      .RS_CNT(RS_CNT)
    ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .valid   (s_axis_input_tvalid[j]),
      .ready   (s_axis_input_tready[j]),
      .data    (s_axis_input_tdata[8*j +: 8]),
      .last    (s_axis_input_tlast[j]),
      .clear   (clear),
      .rd_addr (rd_cnt),
      .rd_data (word[8*j +: 8]),
      .done    (lane_done[j]),
      .len_err (len_err[j])
    );
  end

  // Global FSM plus output register stage; rd_cnt indexes the next word to load
  always_ff @(posedge clk) begin
    if (reset) begin
      gstate               <= G_COLLECT;
      rd_cnt               <= '0;
      m_axis_output_tvalid <= 1'b0;
      m_axis_output_tdata  <= '0;
      m_axis_output_tlast  <= 1'b0;
    end else begin
      case (gstate)
        G_COLLECT: begin
          if (&lane_done) begin
            gstate <= G_OUT;
            rd_cnt <= '0;
          end
        end
        G_OUT: begin
          if (load) begin
            if (m_axis_output_tvalid && m_axis_output_tlast) begin
              m_axis_output_tvalid <= 1'b0;
              m_axis_output_tlast  <= 1'b0;
              gstate               <= G_COLLECT;
            end else begin
              m_axis_output_tdata  <= word;
              m_axis_output_tvalid <= 1'b1;
              m_axis_output_tlast  <= (rd_cnt == LAST_IDX);
              rd_cnt               <= rd_cnt + 12'd1;
            end
          end
        end
        default: gstate <= G_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_deblock.sv
// tb_mac_deblock: scoreboard bench for mac_deblock. Expected words are pushed
// when a frame is launched and popped as the DUT hands them off.
module tb_mac_deblock;

  localparam int RS_CNT = 236;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_tvalid = '0;
  logic [7:0]  s_tready;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tlast = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic [7:0]  len_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [64:0] sb_q[$];
  int unsigned frm_len[8];
  logic        frm_last[8];
  int          frm_delay[8];
  int          seed;
  int          last_hs = 0;
  bit          lat_en = 0;
  bit          bp_en = 0;
  int          mon_words = 0;

  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [63:0] hold_d = '0;
  logic        hold_l = 1'b0;
  logic [64:0] exp_w;

  mac_deblock #(
    .RS_CNT(RS_CNT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tready  (s_tready),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tlast   (s_tlast),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tready (m_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tlast  (m_tlast),
    .len_err              (len_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lane_byte(int j, int k);
    return 8'((j * 16 + k + seed) & 255);
  endfunction

  task automatic set_frame(input int s);
    seed = s;
    for (int j = 0; j < 8; j++) begin
      frm_len[j]   = RS_CNT;
      frm_last[j]  = 1'b1;
      frm_delay[j] = 0;
    end
  endtask

  task automatic push_expected();
    logic [63:0] w;
    for (int k = 0; k < RS_CNT; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++)
        if (k < int'(frm_len[j])) w[8*j +: 8] = lane_byte(j, k);
      sb_q.push_back({(k == RS_CNT - 1), w});
    end
  endtask

  task automatic send_frame();
    int unsigned idx[8];
    int          start;
    int          budget;
    logic [7:0]  pend;
    bit          done_all;
    bit          quiet;
    quiet = (sb_q.size() == 0);
    push_expected();
    start    = cyc;
    pend     = '0;
    budget   = 0;
    done_all = 0;
    for (int j = 0; j < 8; j++) idx[j] = 0;
    while (!done_all && budget < 6000) begin
      budget++;
      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) begin
        if (idx[j] < frm_len[j] && (cyc - start) >= frm_delay[j]) begin
          s_tvalid[j]       = 1'b1;
          s_tdata[8*j +: 8] = lane_byte(j, int'(idx[j]));
          s_tlast[j]        = frm_last[j] && (idx[j] == frm_len[j] - 1);
        end else begin
          s_tvalid[j] = 1'b0;
          s_tlast[j]  = 1'b0;
        end
      end
      @(negedge clk);
      check("len_err", len_err, pend);
      if (quiet) check("out_early", m_tvalid, 0);
      for (int j = 0; j < 8; j++)
        if (idx[j] >= frm_len[j]) check("rdy_done", s_tready[j], 0);
      if (|(s_tvalid & s_tready)) check("early_acc", sb_q.size() <= RS_CNT, 1);
      pend = '0;
      for (int j = 0; j < 8; j++) begin
        if (s_tvalid[j] && s_tready[j]) begin
`ifdef MAC_LEN_CHK_EN
          if (idx[j] == frm_len[j] - 1)
            pend[j] = frm_last[j] ? (frm_len[j] != RS_CNT) : 1'b1;
`endif
          idx[j]++;
          last_hs = cyc + 1;
        end
      end
      done_all = 1;
      for (int j = 0; j < 8; j++)
        if (idx[j] < frm_len[j]) done_all = 0;
    end
    if (!done_all) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = '0;
    s_tlast  = '0;
    @(negedge clk);
    check("len_err", len_err, pend);
    @(negedge clk);
    check("len_err_clr", len_err, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain", sb_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check("idle_valid", m_tvalid, 0);
    check("idle_ready", s_tready, 8'hFF);
  endtask

  // Output-side monitor: hold stability, latency and scoreboard compare
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_tvalid, 1);
          check("hold_data", m_tdata, hold_d);
          check("hold_last", m_tlast, hold_l);
        end
        if (m_tvalid && !prev_valid && lat_en) check("latency", cyc - last_hs, 2);
        if (m_tvalid && m_tready) begin
          if (sb_q.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            exp_w = sb_q.pop_front();
            check("data", m_tdata, exp_w[63:0]);
            check("last", m_tlast, exp_w[64]);
          end
          mon_words++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_valid = m_tvalid;
        hold_d     = m_tdata;
        hold_l     = m_tlast;
      end
    end
  end

  // Downstream ready: always high, or ~30% low when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_len_err", len_err, 0);
    check("rst_s_ready", s_tready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", s_tready, 8'hFF);

    // nominal frame with first-word latency check
    set_frame(0);
    lat_en = 1;
    send_frame();
    wait_drain();
    lat_en = 0;

    // lane 7 arrives 50 cycles late
    set_frame(5);
    frm_delay[7] = 50;
    send_frame();
    wait_drain();

    // two back-to-back frames under random backpressure
    bp_en = 1;
    set_frame(11);
    send_frame();
    set_frame(77);
    send_frame();
    wait_drain();
    bp_en = 0;

    // short frame on lane 3
    set_frame(3);
    frm_len[3] = 10;
    send_frame();
    wait_drain();

    // missing tlast on lane 0, which finishes ahead of the others
    set_frame(9);
    frm_last[0] = 1'b0;
    for (int j = 1; j < 8; j++) frm_delay[j] = 5;
    send_frame();
    wait_drain();

    // reset in the middle of the output phase
    set_frame(21);
    base = mon_words;
    send_frame();
    for (int i = 0; i < 2000 && (mon_words - base) < 100; i++) @(negedge clk);
    check("reach_word100", (mon_words - base) >= 100, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_tready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_valid", m_tvalid, 0);
      check("midrst_last", m_tlast, 0);
    end
    check("midrst_rdy", s_tready, 8'hFF);

    // clean frame after the aborted one
    set_frame(33);
    send_frame();
    wait_drain();
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
